uart_mod_counter: RTL and testbench
===================================

# uart_mod_counter

Runtime-programmable modulo counter, the parametrised successor to the fixed-modulus UART bit/baud counter. Counts up or down modulo a loadable modulus, wraps or stops at the terminal value (one-shot), and reports a combinational terminal flag, a registered wrap pulse and a saturating wrap counter. Sits in the UART datapath as the shared baud-tick divider, bit counter and frame/timeout counter, one instance per use.

## Interface
- `WIDTH`, default 8: counter and modulus width.
- `DEFAULT_MODULUS`, default 9: modulus after reset. Legal range 1..2^WIDTH-1.
- `WRAP_WIDTH`, default 4: width of `wrap_count`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  active high; allows one count step per cycle.
- `syncReset`  in  1  active high; synchronous restart to the start value. It is not gated by `enable`.
- `load`  in  1  active high; captures `load_value` as the new modulus and restarts the count.
- `load_value`  in  WIDTH  new modulus. A value of 0 is stored as 1.
- `dir`  in  1  count direction: 0 = up, 1 = down.
- `one_shot`  in  1  0 = wrap at terminal, 1 = stop at terminal.
- `Counting`  out  WIDTH  current count.
- `Flag`  out  1  combinational; high while `Counting` equals the terminal value.
- `tc_pulse`  out  1  registered; one-cycle pulse following a terminal step.
- `done`  out  1  high while halted in one-shot mode.
- `wrap_count`  out  WRAP_WIDTH  number of wraps since the last restart; saturates.

## Operation
**Registers**
- `mod_reg`: WIDTH bits.
- `cnt`: WIDTH bits.
- `state`: RUN or HALT.
- `tc_pulse`.
- `wrap_count`.

**Derived values**
- Start value: 0 when `dir`=0; `mod_reg-1` when `dir`=1.
- Terminal value: `mod_reg-1` when `dir`=0; 0 when `dir`=1.
- Both are evaluated with the current `dir`.

**Priority per cycle** (highest first)
- syncReset:
  - `cnt` <= start value.
  - state <= RUN.
  - `wrap_count` <= 0.
  - `mod_reg` unchanged.
- load:
  - `mod_reg` <= max(`load_value`, 1).
  - `cnt` <= start value computed from the NEW modulus.
  - state <= RUN.
  - `wrap_count` <= 0.
- enable, state RUN, `cnt` != terminal:
  - `cnt` <= `cnt`+1 when up, `cnt`-1 when down.
- enable, state RUN, `cnt` == terminal:
  - `tc_pulse` <= 1 on the next cycle.
  - If `one_shot`=0: `cnt` <= start value; `wrap_count` <= `wrap_count`+1, saturating at all-ones.
  - If `one_shot`=1: `cnt` holds; state <= HALT; `wrap_count` unchanged.
- Otherwise: hold all registers.

**State machine**
- RUN -> HALT: enabled terminal step with `one_shot`=1.
- HALT -> RUN: only by syncReset or load.
- In HALT, `enable` is ignored and `tc_pulse` stays 0.

**Other rules**
- `done` = (state == HALT).
- `tc_pulse` is 0 in every cycle except the one following an enabled terminal step taken in RUN.
- Modulus 1: start equals terminal; every enabled cycle is a terminal step, so `Flag` stays 1.
- `dir` changing mid-count takes effect on the next step. If the change makes `cnt` equal the new terminal, the next enabled step is a terminal step. No out-of-range count occurs, because `cnt` is always in 0..`mod_reg`-1.
- `one_shot` is sampled only at terminal steps.

## Timing
- Reset values:
  - `Counting`=0.
  - `mod_reg`=`DEFAULT_MODULUS`.
  - state = RUN.
  - `tc_pulse`=0, `done`=0, `wrap_count`=0.
  - `Flag` is 1 after reset only if 0 is the terminal value (`dir`=1 or modulus 1).
- Latency:
  - syncReset, load and count steps are visible on `Counting` the cycle after the edge that samples them.
  - `tc_pulse` is high during the same cycle in which `Counting` shows the wrapped start value.
- `Flag` is combinational from `cnt`, `mod_reg` and `dir`, with no added latency. All other outputs are registered.
- Reset asserted mid-count forces all registers to their reset values immediately and asynchronously.
- Simultaneous syncReset and load: syncReset wins and `load_value` is dropped.

## Test plan
1. Up wrap:
   - Stimulus: reset, modulus 9, `dir`=0, `one_shot`=0, `enable` held for 20 cycles.
   - Required: `Counting` 0..8,0..8,0,1; `Flag` high at 8; `tc_pulse` high when `Counting` returns to 0; `wrap_count`=2.
2. Down one-shot:
   - Stimulus: load 5, `dir`=1, `one_shot`=1, enable for 8 cycles.
   - Required: `Counting` 4,3,2,1,0 then holds 0; single `tc_pulse`; `done`=1 from the cycle after the terminal step onward.
   - Then pulse syncReset: `Counting`=4, `done`=0.
3. Load edge values:
   - Stimulus: load 0 (stored as 1), enable for 4 cycles.
   - Required: `Counting` stays 0, `Flag`=1, `tc_pulse` high on every cycle after the first, `wrap_count`=3.
   - Stimulus: load 255 with WIDTH=8.
   - Required: counts to 254, then wraps.
4. Priority:
   - Stimulus: syncReset, load=1 (value 3) and enable all in the same cycle at `Counting`=6, modulus 9.
   - Required: `Counting`=0, modulus still 9.
   - Stimulus: load plus enable.
   - Required: modulus 3, `Counting`=0.
5. Saturation and async reset:
   - Stimulus: modulus 2, run 40 enabled cycles with WRAP_WIDTH=4.
   - Required: `wrap_count` sticks at 15.
   - Stimulus: drop `reset` mid-cycle.
   - Required: all outputs return to reset values without waiting for a clock edge.
6. Direction change:
   - Stimulus: up count at `Counting`=3, modulus 9; switch `dir`=1.
   - Required: `Counting` 2,1,0, then a terminal step wraps to 8.

Source files
------------

// File: rtl/uart_mod_counter.sv
// Loadable up/down modulo counter with one-shot halt, terminal flag,
// registered wrap pulse and saturating wrap counter.
//
// Ports:
//   clk, reset (async, active low)
//   enable      - one count step per cycle when high
//   syncReset   - synchronous restart to start value (ignores enable)
//   load        - capture load_value as modulus (0 stored as 1), restart
//   load_value  - new modulus
//   dir         - 0 = up, 1 = down
//   one_shot    - 0 = wrap at terminal, 1 = halt at terminal
//   Counting    - current count
//   Flag        - combinational, count equals terminal value
//   tc_pulse    - one-cycle pulse after a terminal step
//   done        - halted in one-shot mode
//   wrap_count  - saturating wraps since last restart
module uart_mod_counter #(
  parameter int WIDTH           = 8,
  parameter int DEFAULT_MODULUS = 9,
  parameter int WRAP_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  syncReset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  dir,
  input  logic                  one_shot,
  output logic [WIDTH-1:0]      Counting,
  output logic                  Flag,
  output logic                  tc_pulse,
  output logic                  done,
  output logic [WRAP_WIDTH-1:0] wrap_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mod_q, mod_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  tc_q, tc_d;
  logic [WRAP_WIDTH-1:0] wrap_q, wrap_d;

  logic [WIDTH-1:0] start_v;
  logic [WIDTH-1:0] term_v;
  logic [WIDTH-1:0] ld_mod;
  logic [WIDTH-1:0] ld_start;

  always_comb begin
    start_v  = dir ? (mod_q - ONE) : '0;
    term_v   = dir ? '0 : (mod_q - ONE);
    ld_mod   = (load_value == '0) ? ONE : load_value;
    // Restart after load uses the new modulus, not mod_q.
    ld_start = dir ? (ld_mod - ONE) : '0;
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    wrap_d  = wrap_q;
    if (syncReset) begin
      cnt_d   = start_v;
      state_d = RUN;
      wrap_d  = '0;
    end else if (load) begin
      mod_d   = ld_mod;
      cnt_d   = ld_start;
      state_d = RUN;
      wrap_d  = '0;
    end else if (enable && state_q == RUN) begin
      if (cnt_q != term_v) begin
        cnt_d = dir ? (cnt_q - ONE) : (cnt_q + ONE);
      end else begin
        tc_d = 1'b1;
        if (one_shot) begin
          state_d = HALT;
        end else begin
          cnt_d = start_v;
          if (wrap_q != '1) begin
            wrap_d = wrap_q + WRAP_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      mod_q   <= WIDTH'(DEFAULT_MODULUS);
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Counting   = cnt_q;
  assign Flag       = (cnt_q == term_v);
  assign tc_pulse   = tc_q;
  assign done       = (state_q == HALT);
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_uart_mod_counter.sv
// Bench for uart_mod_counter: directed scenarios plus random
// stimulus, all checked against a modulo-arithmetic reference model.
module tb_uart_mod_counter;

  localparam int W  = 8;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          syncReset;
  logic          load;
  logic [W-1:0]  load_value;
  logic          dir;
  logic          one_shot;
  logic [W-1:0]  Counting;
  logic          Flag;
  logic          tc_pulse;
  logic          done;
  logic [WW-1:0] wrap_count;

  int total = 0;
  int bad   = 0;

  int m_mod, m_cnt, m_wrap;
  bit m_halt, m_tc;

  always #5 clk = ~clk;

  uart_mod_counter #(
    .WIDTH(W),
    .DEFAULT_MODULUS(9),
    .WRAP_WIDTH(WW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .syncReset(syncReset),
    .load(load),
    .load_value(load_value),
    .dir(dir),
    .one_shot(one_shot),
    .Counting(Counting),
    .Flag(Flag),
    .tc_pulse(tc_pulse),
    .done(done),
    .wrap_count(wrap_count)
  );

  function automatic void model_reset();
    m_mod  = 9;
    m_cnt  = 0;
    m_wrap = 0;
    m_halt = 0;
    m_tc   = 0;
  endfunction

  // Count steps are taken modulo m_mod; a step from the terminal
  // value is exactly the step that wraps around the circle.
  function automatic void model_step();
    int term;
    term = dir ? 0 : m_mod - 1;
    m_tc = 0;
    if (syncReset) begin
      m_cnt  = dir ? m_mod - 1 : 0;
      m_halt = 0;
      m_wrap = 0;
    end else if (load) begin
      m_mod  = (load_value == 0) ? 1 : int'(load_value);
      m_cnt  = dir ? m_mod - 1 : 0;
      m_halt = 0;
      m_wrap = 0;
    end else if (enable && !m_halt) begin
      if (m_cnt == term) begin
        m_tc = 1;
        if (one_shot) m_halt = 1;
        else begin
          m_cnt  = dir ? m_mod - 1 : 0;
          m_wrap = (m_wrap + 1 > 15) ? 15 : m_wrap + 1;
        end
      end else begin
        m_cnt = dir ? (m_cnt + m_mod - 1) % m_mod
                    : (m_cnt + 1) % m_mod;
      end
    end
  endfunction

  function automatic logic [14:0] exp_vec();
    logic f;
    f = (m_cnt == (dir ? 0 : m_mod - 1));
    return {W'(m_cnt), f, m_tc, m_halt, WW'(m_wrap)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable     = 0;
    syncReset  = 0;
    load       = 0;
    load_value = '0;
    dir        = 0;
    one_shot   = 0;
  endtask

  task automatic do_load(input int v);
    load       = 1;
    load_value = W'(v);
    tick();
    load       = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #23;
    total++;
    if ({Counting, Flag, tc_pulse, done, wrap_count} !== 15'd0) begin
      bad++;
      $display("FAIL reset got=%h exp=%h",
               {Counting, Flag, tc_pulse, done, wrap_count}, 15'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_up_wrap();
    dir    = 0;
    enable = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()
          || Counting !== W'(k % 9)) begin
        bad++;
        $display("FAIL up_wrap k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    total++;
    if (wrap_count !== 4'd2) begin
      bad++;
      $display("FAIL up_wrap_count got=%0d exp=2", wrap_count);
    end
    enable = 0;
  endtask

  task automatic test_down_oneshot();
    int tcs;
    tcs      = 0;
    dir      = 1;
    one_shot = 1;
    do_load(5);
    total++;
    if (Counting !== 8'd4) begin
      bad++;
      $display("FAIL down_load got=%0d exp=4", Counting);
    end
    enable = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tcs += tc_pulse;
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()
          || done !== (k >= 5)) begin
        bad++;
        $display("FAIL down_oneshot k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    total++;
    if (tcs != 1 || Counting !== 8'd0) begin
      bad++;
      $display("FAIL down_single_tc got=%0d/%0d exp=1/0", tcs, Counting);
    end
    enable    = 0;
    syncReset = 1;
    tick();
    syncReset = 0;
    total++;
    if (Counting !== 8'd4 || done !== 1'b0) begin
      bad++;
      $display("FAIL down_sync got=%0d/%b exp=4/0", Counting, done);
    end
    one_shot = 0;
    dir      = 0;
  endtask

  task automatic test_load_edges();
    enable     = 1;
    load       = 1;
    load_value = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      load = 0;
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()
          || Flag !== 1'b1 || tc_pulse !== (k > 1)) begin
        bad++;
        $display("FAIL load0 k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    total++;
    if (wrap_count !== 4'd3) begin
      bad++;
      $display("FAIL load0_wrap got=%0d exp=3", wrap_count);
    end
    do_load(255);
    for (int k = 1; k <= 256; k++) begin
      tick();
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()
          || Counting !== W'(k % 255)) begin
        bad++;
        $display("FAIL load255 k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    enable = 0;
  endtask

  task automatic test_priority();
    do_load(9);
    enable = 1;
    repeat (6) tick();
    syncReset  = 1;
    load       = 1;
    load_value = 8'd3;
    tick();
    syncReset = 0;
    load      = 0;
    total++;
    if (Counting !== 8'd0) begin
      bad++;
      $display("FAIL prio_sync got=%0d exp=0", Counting);
    end
    repeat (8) tick();
    total++;
    if (Counting !== 8'd8 || Flag !== 1'b1
        || {Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()) begin
      bad++;
      $display("FAIL prio_mod9 got=%0d/%b exp=8/1", Counting, Flag);
    end
    do_load(3);
    total++;
    if (Counting !== 8'd0) begin
      bad++;
      $display("FAIL prio_load got=%0d exp=0", Counting);
    end
    repeat (2) tick();
    total++;
    if (Counting !== 8'd2 || Flag !== 1'b1) begin
      bad++;
      $display("FAIL prio_mod3 got=%0d/%b exp=2/1", Counting, Flag);
    end
    tick();
    total++;
    if (Counting !== 8'd0 || tc_pulse !== 1'b1) begin
      bad++;
      $display("FAIL prio_wrap got=%0d/%b exp=0/1", Counting, tc_pulse);
    end
    enable = 0;
  endtask

  task automatic test_saturation();
    do_load(2);
    enable = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()) begin
        bad++;
        $display("FAIL sat k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    total++;
    if (wrap_count !== 4'd15) begin
      bad++;
      $display("FAIL sat_wrap got=%0d exp=15", wrap_count);
    end
    tick();
    #2;
    reset = 0;
    #1;
    total++;
    if ({Counting, Flag, tc_pulse, done, wrap_count} !== 15'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h",
               {Counting, Flag, tc_pulse, done, wrap_count}, 15'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset  = 1;
    enable = 0;
  endtask

  task automatic test_dir_change();
    int seq[4] = '{2, 1, 0, 8};
    dir = 0;
    do_load(9);
    enable = 1;
    repeat (3) tick();
    dir = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()
          || Counting !== W'(seq[k]) || tc_pulse !== (k == 3)) begin
        bad++;
        $display("FAIL dir_change k=%0d got=%0d exp=%0d", k,
                 Counting, seq[k]);
      end
    end
    enable = 0;
    dir    = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      enable     = ($urandom_range(3) != 0);
      syncReset  = ($urandom_range(63) == 0);
      load       = ($urandom_range(31) == 0);
      load_value = ($urandom_range(3) == 0) ? W'($urandom_range(3))
                                            : W'($urandom_range(40));
      if ($urandom_range(15) == 0) dir = ~dir;
      one_shot   = ($urandom_range(3) == 0);
      tick();
      total++;
      if ({Counting, Flag, tc_pulse, done, wrap_count} !== exp_vec()) begin
        bad++;
        $display("FAIL random k=%0d got=%h exp=%h", k,
                 {Counting, Flag, tc_pulse, done, wrap_count}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_oneshot();
    test_load_edges();
    test_priority();
    test_saturation();
    test_dir_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
